// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional packet lock enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int ACK_TIMEOUT = 8,
   localparam int IDW        = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_busy,
   output logic [IDW-1:0]       grant_id,
   output logic                 grant_active,
   output logic                 err_timeout,
   output logic [15:0]          tx_count
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t               state_r, next_state_s;
   logic [IDW-1:0]       rr_ptr_r, win_s, idx_s;
   logic                 found_s, grant_s, timeout_s, done_s;
   logic [NUM_REQ-1:0]   elig_s, ready_s;
   logic [7:0]           tx_data_r;
   logic                 tx_start_r, grant_active_r, err_timeout_r;
   logic [IDW-1:0]       grant_id_r;
   logic [15:0]          tx_count_r;
   logic [TW-1:0]        timer_r;

`ifdef UART_ARB_LOCK_EN
   logic                 lock_r;
   logic [IDW-1:0]       lock_id_r;

   // While a packet is open only its owner is eligible
   always_comb begin
      elig_s = req_valid;
      if (lock_r) begin
         elig_s = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << lock_id_r);
      end else begin
         elig_s = req_valid;
      end
   end
`else
   logic                 unused_last_s;

   assign unused_last_s = ^req_last;
   assign elig_s        = req_valid;
`endif

   // Pick the first eligible requester after the round-robin pointer
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_s = IDW'((int'(rr_ptr_r) + k) % NUM_REQ);
         if (!found_s && elig_s[idx_s]) begin
            found_s = 1'b1;
            win_s   = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Next-state and handshake decode
   always_comb begin
      next_state_s = state_r;
      ready_s      = '0;
      grant_s      = 1'b0;
      timeout_s    = 1'b0;
      done_s       = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!tx_busy && found_s) begin
               grant_s         = 1'b1;
               ready_s[win_s]  = 1'b1;
               next_state_s    = ST_START;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_START: next_state_s = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (tx_busy) begin
               next_state_s = ST_WAIT_DONE;
            end else if (timer_r == TW'(ACK_TIMEOUT - 1)) begin
               timeout_s    = 1'b1;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WAIT_ACK;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               done_s       = 1'b1;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WAIT_DONE;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Launch datapath, ack timer and status
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_r       <= IDW'(NUM_REQ - 1);
         tx_data_r      <= 8'h00;
         tx_start_r     <= 1'b0;
         grant_id_r     <= '0;
         grant_active_r <= 1'b0;
         err_timeout_r  <= 1'b0;
         tx_count_r     <= 16'h0000;
         timer_r        <= '0;
      end else begin
         tx_start_r <= grant_s;
         if (grant_s) begin
            tx_data_r      <= req_data[{win_s, 3'b000} +: 8];
            grant_id_r     <= win_s;
            rr_ptr_r       <= win_s;
            grant_active_r <= 1'b1;
            tx_count_r     <= tx_count_r + 16'd1;
         end else if (timeout_s || done_s) begin
            grant_active_r <= 1'b0;
         end
         if (state_r == ST_START) begin
            timer_r <= '0;
         end else if (state_r == ST_WAIT_ACK && !tx_busy) begin
            timer_r <= timer_r + TW'(1);
         end
         if (timeout_s) begin
            err_timeout_r <= 1'b1;
         end
      end
   end

`ifdef UART_ARB_LOCK_EN
   // Packet lock follows req_last of each granted byte; a timeout drops it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_r    <= 1'b0;
         lock_id_r <= '0;
      end else if (grant_s) begin
         lock_r    <= ~req_last[win_s];
         lock_id_r <= win_s;
      end else if (timeout_s) begin
         lock_r    <= 1'b0;
      end
   end
`endif

   assign req_ready    = ready_s & {NUM_REQ{~rst}};
   assign tx_data      = tx_data_r;
   assign tx_start     = tx_start_r;
   assign grant_id     = grant_id_r;
   assign grant_active = grant_active_r;
   assign err_timeout  = err_timeout_r;
   assign tx_count     = tx_count_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a transaction-level model.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int TO = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
   logic [8*N-1:0] req_data = '0;
   logic [7:0]     tx_data;
   logic           tx_start, grant_active, err_timeout;
   logic           tx_busy = 1'b0;
   logic [1:0]     grant_id;
   logic [15:0]    tx_count;

   uart_tx_arbiter #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
      .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
      .grant_active(grant_active), .err_timeout(err_timeout), .tx_count(tx_count)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   logic [8:0] q[N][$];            // {last, data} per requester
   int         launch_id[$];
   logic [7:0] launch_data[$];

   // transaction model: 0 idle, 1 launch due, 2 awaiting busy, 3 awaiting done
   int   phase, ackwait, last_win, exp_cnt, exp_id, lock_id;
   logic [7:0] exp_data;
   bit   exp_err, lock_on, lock_model;
   // transmitter / stimulus environment
   bit   auto_ack, force_busy, rand_valid, rand_frame;
   int   busy_left, noack_pct;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N; i++) begin
         if (q[i].size() > 0 && (!rand_valid || $urandom_range(3) != 0)) begin
            req_valid[i]       = 1'b1;
            req_data[8*i +: 8] = q[i][0][7:0];
            req_last[i]        = q[i][0][8];
         end else begin
            req_valid[i]       = 1'b0;
            req_data[8*i +: 8] = 8'h00;
            req_last[i]        = 1'b0;
         end
      end
   endtask

   function automatic int predict();
      int w = -1;
      for (int k = 1; k <= N; k++) begin
         int c;
         c = (last_win + k) % N;
         if (w < 0 && req_valid[c] && (!(lock_model && lock_on) || c == lock_id)) w = c;
      end
      return w;
   endfunction

   task automatic tick();
      logic [N-1:0] exp_rdy;
      int w;
      @(negedge clk);
      exp_rdy = '0;
      w = -1;
      if (phase == 0 && tx_busy == 1'b0) begin
         w = predict();
         if (w >= 0) exp_rdy[w] = 1'b1;
      end
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_eq("grant_active", 32'(grant_active), 32'(phase != 0));
      check_eq("err_timeout", 32'(err_timeout), 32'(exp_err));
      check_eq("tx_start", 32'(tx_start), 32'(phase == 1));
      if (tx_start) begin
         launch_id.push_back(int'(grant_id));
         launch_data.push_back(tx_data);
         if (auto_ack && $urandom_range(99) >= noack_pct)
            busy_left = rand_frame ? int'($urandom_range(12, 1)) : 10;
      end
      case (phase)
         0: if (w >= 0) begin
               exp_data = q[w][0][7:0];
               exp_id   = w;
               exp_cnt++;
               last_win = w;
               if (lock_model) begin
                  lock_on = !q[w][0][8];
                  lock_id = w;
               end
               void'(q[w].pop_front());
               phase = 1;
            end
         1: begin
               check_eq("tx_data", 32'(tx_data), 32'(exp_data));
               check_eq("grant_id", 32'(grant_id), 32'(exp_id));
               check_eq("tx_count", 32'(tx_count), 32'(exp_cnt & 16'hFFFF));
               phase   = 2;
               ackwait = 0;
            end
         2: if (tx_busy) phase = 3;
            else begin
               ackwait++;
               if (ackwait == TO) begin
                  phase   = 0;
                  exp_err = 1'b1;
                  lock_on = 1'b0;
               end
            end
         3: if (!tx_busy) phase = 0;
         default: phase = 0;
      endcase
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
         tx_busy = 1'b1;
         busy_left--;
      end else begin
         tx_busy = force_busy;
      end
      drive_inputs();
   endtask

   task automatic run_idle(input int max);
      int n = 0;
      while ((phase != 0 || q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0) && n < max) begin
         tick();
         n++;
      end
      if (n >= max) check_eq("idle_bound", 32'(n), 32'(0));
      repeat (3) tick();
   endtask

   task automatic do_reset();
      for (int i = 0; i < N; i++) q[i].delete();
      req_valid = '0; req_data = '0; req_last = '0;
      busy_left = 0; force_busy = 1'b0; tx_busy = 1'b0;
      #1 rst = 1'b1;
      #1;
      check_eq("rst_tx_start", 32'(tx_start), 32'(0));
      check_eq("rst_grant_active", 32'(grant_active), 32'(0));
      check_eq("rst_tx_count", 32'(tx_count), 32'(0));
      check_eq("rst_err", 32'(err_timeout), 32'(0));
      check_eq("rst_tx_data", 32'(tx_data), 32'(0));
      check_eq("rst_grant_id", 32'(grant_id), 32'(0));
      check_eq("rst_ready", 32'(req_ready), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      phase = 0; last_win = N - 1; exp_err = 1'b0; exp_cnt = 0; lock_on = 1'b0; lock_id = 0;
      launch_id.delete();
      launch_data.delete();
      @(posedge clk);
      #1;
   endtask

   int t3_exp[6] = '{0, 1, 2, 3, 0, 1};
`ifdef UART_ARB_LOCK_EN
   int t6_exp[5] = '{1, 1, 1, 2, 2};
   initial lock_model = 1'b1;
`else
   int t6_exp[5] = '{1, 2, 1, 2, 1};
   initial lock_model = 1'b0;
`endif

   initial begin
      auto_ack = 1'b1; force_busy = 1'b0; rand_valid = 1'b0; rand_frame = 1'b0;
      noack_pct = 0; busy_left = 0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // single byte
      q[0].push_back({1'b1, 8'h55});
      drive_inputs();
      run_idle(100);
      check_eq("t2_n", 32'(launch_data.size()), 32'(1));
      check_eq("t2_data", 32'(launch_data[0]), 32'h55);
      check_eq("t2_count", 32'(tx_count), 32'(1));

      // reset while the transmitter is mid-frame
      q[0].push_back({1'b1, 8'h3C});
      drive_inputs();
      for (int n = 0; n < 60 && phase != 3; n++) tick();
      repeat (2) tick();
      check_eq("t1_active", 32'(grant_active), 32'(1));
      do_reset();

      // fairness with all requesters continuously valid
      for (int i = 0; i < N; i++)
         for (int j = 0; j < 3; j++) q[i].push_back({1'b1, 8'(8'hA0 + i)});
      drive_inputs();
      run_idle(600);
      check_eq("t3_n", 32'(launch_id.size()), 32'(12));
      for (int i = 0; i < 6; i++) begin
         check_eq("t3_order", 32'(launch_id[i]), 32'(t3_exp[i]));
         check_eq("t3_data", 32'(launch_data[i]), 32'(8'hA0 + t3_exp[i]));
      end

      // busy hold-off
      launch_id.delete();
      force_busy = 1'b1;
      tx_busy = 1'b1;
      q[1].push_back({1'b1, 8'h77});
      drive_inputs();
      repeat (20) tick();
      check_eq("t4_held", 32'(launch_id.size()), 32'(0));
      force_busy = 1'b0;
      run_idle(100);
      check_eq("t4_served", 32'(launch_id.size()), 32'(1));

      // timeout, then recovery
      auto_ack = 1'b0;
      q[2].push_back({1'b1, 8'h99});
      drive_inputs();
      run_idle(100);
      check_eq("t5_err", 32'(err_timeout), 32'(1));
      auto_ack = 1'b1;
      q[3].push_back({1'b1, 8'h42});
      drive_inputs();
      run_idle(100);
      check_eq("t5_next_id", 32'(launch_id[launch_id.size()-1]), 32'(3));
      check_eq("t5_next_data", 32'(launch_data[launch_data.size()-1]), 32'h42);
      do_reset();

      // packet lock behaviour
      q[1].push_back({1'b0, 8'h11});
      q[1].push_back({1'b0, 8'h12});
      q[1].push_back({1'b1, 8'h13});
      q[2].push_back({1'b1, 8'h21});
      q[2].push_back({1'b1, 8'h22});
      drive_inputs();
      run_idle(400);
      check_eq("t6_n", 32'(launch_id.size()), 32'(5));
      for (int i = 0; i < 5; i++) check_eq("t6_order", 32'(launch_id[i]), 32'(t6_exp[i]));
      do_reset();

      // randomized traffic, frames and dropped acks
      rand_valid = 1'b1; rand_frame = 1'b1; noack_pct = 10;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            int cnt;
            cnt = int'($urandom_range(4));
            for (int j = 0; j < cnt; j++)
               q[i].push_back({(j == cnt - 1) ? 1'b1 : 1'($urandom_range(1)), 8'($urandom)});
         end
         drive_inputs();
         run_idle(3000);
      end
      check_eq("rand_count", 32'(tx_count), 32'(exp_cnt));
      check_eq("rand_launches", 32'(launch_data.size()), 32'(exp_cnt));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
